mem_port_arbiter: RTL and testbench

//  Shares one single-ported memory between two requesters: port 0 (multicycle rv32i core)
//  and port 1 (debug/DMA loader). Grants at most one access per cycle using round-robin

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_port_arbiter_rd_tag_pipe.sv | 31 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Port ids, read-response tags and lock state.
package mem_arb_pkg;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic     vld;
        port_id_t id;
    } rd_tag_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lock_state_t;

    localparam int MAX_RD_LATENCY = 4;

    function automatic port_id_t other_port(port_id_t p);
        return (p == PORT0) ? PORT1 : PORT0;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Read-response tag delay line: a tag pushed in appears on tag_out
// exactly DEPTH cycles later. Ports: clk, rst (sync, active-high), tag_in, tag_out.
import mem_arb_pkg::*;

module rd_tag_pipe #(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst,
    input  rd_tag_t tag_in,
    output rd_tag_t tag_out
);

    rd_tag_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter (with lock) in front of a single-ported memory.
// Ports: clk, rst (sync, active-high); per port N: reqN_valid/addr/wr_data/wr_ena/lock in,
// reqN_ready/rd_vld/rd_data out; memory side: mem_addr/wr_data/wr_ena out, mem_rd_data in.
import mem_arb_pkg::*;

module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wr_data,
    input  logic              req0_wr_ena,
    input  logic              req0_lock,
    output logic              req0_ready,
    output logic              req0_rd_vld,
    output logic [DATA_W-1:0] req0_rd_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wr_data,
    input  logic              req1_wr_ena,
    input  logic              req1_lock,
    output logic              req1_ready,
    output logic              req1_rd_vld,
    output logic [DATA_W-1:0] req1_rd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_wr_ena,
    input  logic [DATA_W-1:0] mem_rd_data
);

    port_id_t    last_grant;
    port_id_t    lock_owner;
    lock_state_t lock_state;
    lock_state_t lock_next;

    logic        gnt0;
    logic        gnt1;
    logic        xfer;
    logic        locked;
    logic        both;
    logic        owner_valid;
    port_id_t    win_id;
    logic        win_lock;
    logic        win_wr;

    rd_tag_t     tag_in;
    rd_tag_t     tag_out;

    assign locked      = (lock_state == LOCKED);
    assign both        = req0_valid & req1_valid;
    assign owner_valid = (lock_owner == PORT0) ? req0_valid : req1_valid;

    // Grants are forced off during reset so nothing reaches memory.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            unique case (1'b1)
                locked: begin
                    gnt0 = (lock_owner == PORT0) & req0_valid;
                    gnt1 = (lock_owner == PORT1) & req1_valid;
                end
                (!locked && both): begin
                    gnt0 = (last_grant == PORT1);
                    gnt1 = (last_grant == PORT0);
                end
                default: begin
                    gnt0 = req0_valid;
                    gnt1 = req1_valid;
                end
            endcase
        end
    end

    assign xfer     = gnt0 | gnt1;
    assign win_id   = gnt1 ? PORT1 : PORT0;
    assign win_lock = gnt1 ? req1_lock : req0_lock;
    assign win_wr   = gnt1 ? req1_wr_ena : req0_wr_ena;

    // Owner keeps the lock by transferring with lock=1; an idle owner
    // cycle drops it.
    always_comb begin
        lock_next = lock_state;
        if (xfer) begin
            lock_next = win_lock ? LOCKED : UNLOCKED;
        end else if (locked && !owner_valid) begin
            lock_next = UNLOCKED;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_state <= UNLOCKED;
            lock_owner <= PORT0;
            last_grant <= PORT1;
        end else begin
            lock_state <= lock_next;
            if (xfer) begin
                lock_owner <= win_id;
                last_grant <= win_id;
            end
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    always_comb begin
        mem_addr    = '0;
        mem_wr_data = '0;
        mem_wr_ena  = 1'b0;
        unique case (1'b1)
            gnt0: begin
                mem_addr    = req0_addr;
                mem_wr_data = req0_wr_data;
                mem_wr_ena  = req0_wr_ena;
            end
            gnt1: begin
                mem_addr    = req1_addr;
                mem_wr_data = req1_wr_data;
                mem_wr_ena  = req1_wr_ena;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        tag_in     = '0;
        tag_in.vld = xfer & ~win_wr;
        tag_in.id  = win_id;
    end

    rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_rd_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    // Responses in flight when reset hits are dropped, including the
    // reset cycle itself.
    assign req0_rd_vld  = ~rst & tag_out.vld & (tag_out.id == PORT0);
    assign req1_rd_vld  = ~rst & tag_out.vld & (tag_out.id == PORT1);
    assign req0_rd_data = mem_rd_data;
    assign req1_rd_data = mem_rd_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: three builds (RD_LATENCY 1, 2, 4) share one
// stimulus stream and are compared against a cycle-level reference model.
module tb_mem_port_arbiter;

    localparam int N = 3;

    function automatic int lat_of(int g);
        case (g)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        v   [2];
    logic        wr  [2];
    logic        lk  [2];
    logic [31:0] adr [2];
    logic [31:0] wd  [2];

    logic        rdy0 [N];
    logic        rdy1 [N];
    logic        rv0  [N];
    logic        rv1  [N];
    logic        mwe  [N];
    logic [31:0] rd0  [N];
    logic [31:0] rd1  [N];
    logic [31:0] maddr[N];
    logic [31:0] mwd  [N];
    logic [31:0] mrd  [N];

    logic [31:0] dq [N][4];

    genvar g;
    generate
        for (g = 0; g < N; g++) begin : gen_dut
            mem_port_arbiter #(
                .ADDR_W     (32),
                .DATA_W     (32),
                .RD_LATENCY (lat_of(g))
            ) dut (
                .clk          (clk),
                .rst          (rst),
                .req0_valid   (v[0]),
                .req0_addr    (adr[0]),
                .req0_wr_data (wd[0]),
                .req0_wr_ena  (wr[0]),
                .req0_lock    (lk[0]),
                .req0_ready   (rdy0[g]),
                .req0_rd_vld  (rv0[g]),
                .req0_rd_data (rd0[g]),
                .req1_valid   (v[1]),
                .req1_addr    (adr[1]),
                .req1_wr_data (wd[1]),
                .req1_wr_ena  (wr[1]),
                .req1_lock    (lk[1]),
                .req1_ready   (rdy1[g]),
                .req1_rd_vld  (rv1[g]),
                .req1_rd_data (rd1[g]),
                .mem_addr     (maddr[g]),
                .mem_wr_data  (mwd[g]),
                .mem_wr_ena   (mwe[g]),
                .mem_rd_data  (mrd[g])
            );
            assign mrd[g] = dq[g][lat_of(g)-1];
        end
    endgenerate

    function automatic logic [31:0] init_val(logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (a ^ 32'hC0DE0000);
    endfunction

    // Memory model attached to the DUTs (storage only, no arbitration).
    logic [31:0] hmem [bit [31:0]];
    logic [31:0] s_addr [N];
    logic        s_we;
    logic [31:0] s_waddr;
    logic [31:0] s_wd;

    function automatic logic [31:0] hm_rd(logic [31:0] a);
        return hmem.exists(a) ? hmem[a] : init_val(a);
    endfunction

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) s_addr[i] = maddr[i];
        s_we    = mwe[0];
        s_waddr = maddr[0];
        s_wd    = mwd[0];
    end

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            for (int k = 3; k > 0; k--) dq[i][k] = dq[i][k-1];
            dq[i][0] = hm_rd(s_addr[i]);
        end
        if (s_we) hmem[s_waddr] = s_wd;
    end

    // Reference model state
    logic [31:0] rmem [bit [31:0]];
    int          locked   = -1;
    int          prefer   = 0;
    int          cyc      = 0;
    int          last_rst = -100;
    int          iss_port [int];
    logic [31:0] iss_data [int];

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] rm_rd(logic [31:0] a);
        return rmem.exists(a) ? rmem[a] : init_val(a);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        int          w;
        int          src;
        int          l;
        logic [31:0] ea;
        logic [31:0] ed;
        logic        ewe;
        logic        e0;
        logic        e1;
        @(negedge clk);
        w = -1;
        if (rst) begin
            last_rst = cyc;
        end else if (locked >= 0) begin
            w = v[locked] ? locked : -1;
        end else if (v[0] && v[1]) begin
            w = prefer;
        end else if (v[0]) begin
            w = 0;
        end else if (v[1]) begin
            w = 1;
        end
        ea  = (w >= 0) ? adr[w] : 32'h0;
        ed  = (w >= 0) ? wd[w]  : 32'h0;
        ewe = (w >= 0) ? wr[w]  : 1'b0;
        for (int i = 0; i < N; i++) begin
            l   = lat_of(i);
            chk($sformatf("L%0d ready0", l), 32'(rdy0[i]), 32'(w == 0));
            chk($sformatf("L%0d ready1", l), 32'(rdy1[i]), 32'(w == 1));
            chk($sformatf("L%0d mem_addr", l), maddr[i], ea);
            chk($sformatf("L%0d mem_wr_data", l), mwd[i], ed);
            chk($sformatf("L%0d mem_wr_ena", l), 32'(mwe[i]), 32'(ewe));
            src = cyc - l;
            e0  = iss_port.exists(src) && iss_port[src] == 0 && last_rst <= src;
            e1  = iss_port.exists(src) && iss_port[src] == 1 && last_rst <= src;
            chk($sformatf("L%0d rd_vld0", l), 32'(rv0[i]), 32'(e0));
            chk($sformatf("L%0d rd_vld1", l), 32'(rv1[i]), 32'(e1));
            if (e0) chk($sformatf("L%0d rd_data0", l), rd0[i], iss_data[src]);
            if (e1) chk($sformatf("L%0d rd_data1", l), rd1[i], iss_data[src]);
        end
        @(posedge clk);
        if (rst) begin
            locked = -1;
            prefer = 0;
        end else if (w >= 0) begin
            prefer = 1 - w;
            locked = lk[w] ? w : -1;
            if (wr[w]) begin
                rmem[adr[w]] = wd[w];
            end else begin
                iss_port[cyc] = w;
                iss_data[cyc] = rm_rd(adr[w]);
            end
        end else if (locked >= 0 && !v[locked]) begin
            locked = -1;
        end
        cyc++;
        #1;
    endtask

    task automatic set(int p, logic val, logic we, logic [31:0] a,
                       logic [31:0] d, logic lock);
        v[p]   = val;
        wr[p]  = we;
        adr[p] = a;
        wd[p]  = d;
        lk[p]  = lock;
    endtask

    task automatic idle();
        set(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic idle_steps(int n);
        idle();
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;
        idle_steps(1);

        // Single read from port 0
        set(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        step();
        idle_steps(5);

        // Contention: alternating grants, responses in order
        for (int i = 0; i < 4; i++) begin
            set(0, 1'b1, 1'b0, 32'h40 + 32'(i * 4), 32'h0, 1'b0);
            set(1, 1'b1, 1'b0, 32'h80 + 32'(i * 4), 32'h0, 1'b0);
            step();
        end
        idle_steps(5);

        // Port 1 write, then read it back from port 0
        set(1, 1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0);
        step();
        idle_steps(1);
        set(0, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0);
        step();
        idle_steps(5);

        // Port 1 locked for 3 transfers while port 0 waits
        set(1, 1'b1, 1'b0, 32'h30, 32'h0, 1'b1);
        step();
        set(0, 1'b1, 1'b0, 32'h34, 32'h0, 1'b0);
        set(1, 1'b1, 1'b1, 32'h38, 32'h11111111, 1'b1);
        step();
        set(1, 1'b1, 1'b0, 32'h38, 32'h0, 1'b1);
        step();
        set(1, 1'b1, 1'b0, 32'h3C, 32'h0, 1'b0);
        step();
        set(1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step();
        idle_steps(5);

        // Lock released by the owner going idle for one cycle
        set(0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b1);
        step();
        set(0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        set(1, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0);
        step();
        step();
        idle_steps(5);

        // Reset one cycle after a read transfer
        set(0, 1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
        step();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_steps(6);

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            for (int p = 0; p < 2; p++) begin
                set(p, 1'($urandom_range(0, 3) != 0),
                    1'($urandom_range(0, 2) == 0),
                    32'($urandom_range(0, 15)) << 2,
                    $urandom,
                    1'($urandom_range(0, 5) == 0));
            end
            rst = 1'($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle_steps(6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
